packet_serializer: RTL and testbench



---
 rtl/packet_serializer_pkg.sv | 14 +
 rtl/packet_serializer.sv | 99 +++++++++
 tb/tb_packet_serializer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_serializer_pkg.sv
// Shared types and framing constants for the packet serializer.
package packet_serializer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPayload,
        StWait
    } state_e;

    localparam int unsigned LenWidth = 16;
    localparam int unsigned LenLsb   = 0;

endpackage

// File: rtl/packet_serializer.sv
// Pops framed packet words from the ring buffer and emits them MSB-first as flits,
// flagging the last flit of each packet with eop_o.
module packet_serializer
    import packet_serializer_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned FLIT_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 rx_i,
    output logic                 rx_ack_o,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic                 tx_o,
    input  logic                 tx_ack_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 eop_o
);

    localparam int unsigned NumFlits = DATA_SIZE / FLIT_SIZE;
    localparam int unsigned CntWidth = $clog2(NumFlits);
    localparam logic [CntWidth-1:0] LastFlit = CntWidth'(NumFlits - 1);

    if (DATA_SIZE % FLIT_SIZE != 0) begin : g_bad_ratio
        $error("DATA_SIZE must be an integer multiple of FLIT_SIZE");
    end
    if (NumFlits < 2 || (NumFlits & (NumFlits - 1)) != 0) begin : g_bad_count
        $error("DATA_SIZE/FLIT_SIZE must be a power of two and at least 2");
    end

    state_e                state_q, state_d;
    logic [DATA_SIZE-1:0]  word_q, word_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [LenWidth-1:0]   rem_q, rem_d;

    logic holding, last_flit, accept, accept_last, load, to_header;

    assign holding     = (state_q == StHeader) || (state_q == StPayload);
    assign last_flit   = (cnt_q == LastFlit);
    assign accept      = holding && tx_ack_i;
    assign accept_last = accept && last_flit;
    assign load        = rst_ni && rx_i && !flush_i &&
                         ((state_q == StIdle) || (state_q == StWait) || accept_last);
    // rem_q counts payload words still to come, so zero while holding means the packet ends here.
    assign to_header   = (state_q == StIdle) || (holding && (rem_q == '0));

    assign rx_ack_o = load;
    assign tx_o     = holding;
    assign data_o   = word_q[DATA_SIZE-1 -: FLIT_SIZE];
    assign eop_o    = holding && last_flit && (rem_q == '0);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        if (flush_i) begin
            state_d = StIdle;
            word_d  = '0;
            cnt_d   = '0;
            rem_d   = '0;
        end else begin
            if (accept) begin
                word_d = word_q << FLIT_SIZE;
                cnt_d  = cnt_q + 1'b1;
            end
            if (accept_last) begin
                state_d = (rem_q == '0) ? StIdle : StWait;
            end
            if (load) begin
                word_d = data_i;
                cnt_d  = '0;
                if (to_header) begin
                    state_d = StHeader;
                    rem_d   = data_i[LenLsb +: LenWidth];
                end else begin
                    state_d = StPayload;
                    rem_d   = rem_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            word_q  <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_packet_serializer.sv
// Self-checking bench for packet_serializer: directed framing scenarios plus randomized
// handshakes compared against a packet-level flit model.
module tb_packet_serializer;

    typedef logic [31:0] word_t;
    typedef word_t       word_q_t[$];
    typedef logic [7:0]  flit_q_t[$];
    typedef bit          bit_q_t[$];

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        rx_i = 1'b0;
    logic        tx_ack_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        rx_ack_o, tx_o, eop_o;
    logic [7:0]  data_o;

    int checks = 0;
    int failures = 0;

    logic       o_tx, o_eop, o_rxack;
    logic [7:0] o_data;
    flit_q_t    acc_data;
    bit_q_t     acc_eop;
    int         pops, gaps, stall_viol, ack_viol;

    always #5 clk = ~clk;

    packet_serializer #(
        .DATA_SIZE(32),
        .FLIT_SIZE(8)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .rx_i    (rx_i),
        .rx_ack_o(rx_ack_o),
        .data_i  (data_i),
        .tx_o    (tx_o),
        .tx_ack_i(tx_ack_i),
        .data_o  (data_o),
        .eop_o   (eop_o)
    );

    // Packet-level model: header, then header[15:0] payload words, each split MSB-first.
    function automatic void model(input word_q_t w, output flit_q_t f, output bit_q_t e);
        int idx = 0;
        int n;
        f = {};
        e = {};
        while (idx < w.size()) begin
            n = int'(w[idx][15:0]);
            for (int j = 0; j < 4; j++) begin
                f.push_back(8'(w[idx] >> (24 - 8 * j)));
                e.push_back((n == 0) && (j == 3));
            end
            idx++;
            for (int k = 1; k <= n && idx < w.size(); k++) begin
                for (int j = 0; j < 4; j++) begin
                    f.push_back(8'(w[idx] >> (24 - 8 * j)));
                    e.push_back((k == n) && (j == 3));
                end
                idx++;
            end
        end
    endfunction

    // Drive one cycle from a negedge, sample outputs 1 time unit later, end on next negedge.
    task automatic cyc(input bit rx, input word_t d, input bit ack, input bit fl);
        rx_i = rx;
        data_i = d;
        tx_ack_i = ack;
        flush_i = fl;
        #1;
        o_tx = tx_o;
        o_data = data_o;
        o_eop = eop_o;
        o_rxack = rx_ack_o;
        @(negedge clk);
    endtask

    task automatic drive_stream(input word_q_t w, input int rx_pct, input int ack_pct,
                                input bit_q_t ack_pat, input int stall_word,
                                input int stall_cycles, input int max_cycles);
        int wi = 0;
        int n = 0;
        int stall_left = stall_cycles;
        int exp_n;
        bit rx, ack;
        bit prev_tx = 1'b0;
        bit prev_ack = 1'b0;
        logic [7:0] prev_data = '0;
        word_t d;
        exp_n = w.size() * 4;
        acc_data = {};
        acc_eop = {};
        pops = 0;
        gaps = 0;
        stall_viol = 0;
        ack_viol = 0;
        while (acc_data.size() < exp_n && n < max_cycles) begin
            if (wi == stall_word && stall_left > 0) begin
                rx = 1'b0;
                stall_left--;
            end else begin
                rx = (wi < w.size()) && ($urandom_range(99) < rx_pct);
            end
            d = rx ? w[wi] : $urandom();
            if (ack_pat.size() > 0) ack = ack_pat[n % ack_pat.size()];
            else ack = ($urandom_range(99) < ack_pct);
            cyc(rx, d, ack, 1'b0);
            if (prev_tx && !prev_ack && (!o_tx || o_data !== prev_data)) stall_viol++;
            if (o_rxack && o_tx && !ack) ack_viol++;
            if (o_tx && ack) begin
                acc_data.push_back(o_data);
                acc_eop.push_back(o_eop);
            end else if (!o_tx && acc_data.size() > 0) begin
                gaps++;
            end
            if (rx && o_rxack) begin
                wi++;
                pops++;
            end
            prev_tx = o_tx;
            prev_ack = ack;
            prev_data = o_data;
            n++;
        end
        rx_i = 1'b0;
        tx_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        rx_i = 1'b1;
        data_i = $urandom();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (tx_o !== 1'b0) begin failures++; $display("FAIL reset_tx: got %b want 0", tx_o); end
        checks++; if (eop_o !== 1'b0) begin failures++; $display("FAIL reset_eop: got %b want 0", eop_o); end
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", data_o); end
        checks++; if (rx_ack_o !== 1'b0) begin failures++; $display("FAIL reset_rxack: got %b want 0", rx_ack_o); end
        @(negedge clk);
        rx_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        word_q_t w;
        flit_q_t ef;
        bit_q_t ee;
        bit_q_t none;
        w.push_back(32'h0000_0002);
        w.push_back(32'hAABB_CCDD);
        w.push_back(32'h1122_3344);
        model(w, ef, ee);
        drive_stream(w, 100, 100, none, -1, 0, 100);
        checks++; if (acc_data.size() != 12) begin failures++; $display("FAIL basic_count: got %0d want 12", acc_data.size()); end
        for (int i = 0; i < 12 && i < acc_data.size(); i++) begin
            checks++;
            if (acc_data[i] !== ef[i] || acc_eop[i] !== ee[i]) begin
                failures++;
                $display("FAIL basic_flit[%0d]: got %h/eop%b want %h/eop%b", i, acc_data[i], acc_eop[i], ef[i], ee[i]);
            end
        end
        checks++; if (pops != 3) begin failures++; $display("FAIL basic_pops: got %0d want 3", pops); end
        checks++; if (gaps != 0) begin failures++; $display("FAIL basic_bubbles: got %0d want 0", gaps); end
    endtask

    task automatic test_back_to_back();
        word_q_t w;
        flit_q_t ef;
        bit_q_t ee;
        bit_q_t none;
        w.push_back(32'h0000_0000);
        w.push_back(32'h0000_0001);
        w.push_back(32'hCAFE_F00D);
        model(w, ef, ee);
        drive_stream(w, 100, 100, none, -1, 0, 100);
        checks++; if (acc_data.size() != 12) begin failures++; $display("FAIL b2b_count: got %0d want 12", acc_data.size()); end
        for (int i = 0; i < 12 && i < acc_data.size(); i++) begin
            checks++;
            if (acc_data[i] !== ef[i] || acc_eop[i] !== ee[i]) begin
                failures++;
                $display("FAIL b2b_flit[%0d]: got %h/eop%b want %h/eop%b", i, acc_data[i], acc_eop[i], ef[i], ee[i]);
            end
        end
        checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_bubbles: got %0d want 0", gaps); end
    endtask

    task automatic test_backpressure();
        word_q_t w;
        flit_q_t ef;
        bit_q_t ee;
        bit_q_t pat;
        w.push_back(32'h5A5A_0001);
        w.push_back(32'hDEAD_BEEF);
        pat.push_back(1'b1);
        pat.push_back(1'b0);
        pat.push_back(1'b0);
        pat.push_back(1'b1);
        model(w, ef, ee);
        drive_stream(w, 100, 0, pat, -1, 0, 200);
        checks++; if (acc_data.size() != 8) begin failures++; $display("FAIL bp_count: got %0d want 8", acc_data.size()); end
        for (int i = 0; i < 8 && i < acc_data.size(); i++) begin
            checks++;
            if (acc_data[i] !== ef[i] || acc_eop[i] !== ee[i]) begin
                failures++;
                $display("FAIL bp_flit[%0d]: got %h/eop%b want %h/eop%b", i, acc_data[i], acc_eop[i], ef[i], ee[i]);
            end
        end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol); end
        checks++; if (ack_viol != 0) begin failures++; $display("FAIL bp_rxack: got %0d early pops want 0", ack_viol); end
        checks++; if (pops != 2) begin failures++; $display("FAIL bp_pops: got %0d want 2", pops); end
    endtask

    task automatic test_underflow();
        word_q_t w;
        flit_q_t ef;
        bit_q_t ee;
        bit_q_t none;
        w.push_back(32'h0000_0002);
        w.push_back(32'h0102_0304);
        // Low half nonzero: misparsed as a header it would never raise eop.
        w.push_back(32'h5566_7788);
        model(w, ef, ee);
        drive_stream(w, 100, 100, none, 2, 5, 200);
        checks++; if (acc_data.size() != 12) begin failures++; $display("FAIL uf_count: got %0d want 12", acc_data.size()); end
        for (int i = 0; i < 12 && i < acc_data.size(); i++) begin
            checks++;
            if (acc_data[i] !== ef[i] || acc_eop[i] !== ee[i]) begin
                failures++;
                $display("FAIL uf_flit[%0d]: got %h/eop%b want %h/eop%b", i, acc_data[i], acc_eop[i], ef[i], ee[i]);
            end
        end
        checks++; if (gaps == 0) begin failures++; $display("FAIL uf_gap: got %0d idle cycles want >0", gaps); end
        checks++; if (pops != 3) begin failures++; $display("FAIL uf_pops: got %0d want 3", pops); end
    endtask

    task automatic test_flush();
        word_t hdr = 32'h0000_0003;
        word_t p1 = 32'h1234_5678;
        word_t p2 = 32'h9ABC_DEF0;
        cyc(1'b1, hdr, 1'b1, 1'b0);
        checks++; if (o_rxack !== 1'b1) begin failures++; $display("FAIL fl_hdr_pop: got %b want 1", o_rxack); end
        for (int j = 0; j < 4; j++) begin
            cyc(1'b1, p1, 1'b1, 1'b0);
            checks++;
            if (o_tx !== 1'b1 || o_data !== 8'(hdr >> (24 - 8 * j)) || o_rxack !== (j == 3)) begin
                failures++;
                $display("FAIL fl_hdr_flit[%0d]: got tx%b %h ack%b want tx1 %h ack%b", j, o_tx, o_data, o_rxack, 8'(hdr >> (24 - 8 * j)), j == 3);
            end
        end
        cyc(1'b1, p2, 1'b1, 1'b0);
        checks++; if (o_data !== 8'h12) begin failures++; $display("FAIL fl_pay0: got %h want 12", o_data); end
        cyc(1'b1, p2, 1'b1, 1'b1);
        checks++; if (o_data !== 8'h34 || o_rxack !== 1'b0) begin failures++; $display("FAIL fl_flush_cycle: got %h ack%b want 34 ack0", o_data, o_rxack); end
        cyc(1'b1, p2, 1'b1, 1'b1);
        checks++; if (o_tx !== 1'b0 || o_rxack !== 1'b0) begin failures++; $display("FAIL fl_after: got tx%b ack%b want tx0 ack0", o_tx, o_rxack); end
        cyc(1'b1, 32'h0, 1'b1, 1'b0);
        checks++; if (o_tx !== 1'b0 || o_rxack !== 1'b1) begin failures++; $display("FAIL fl_repop: got tx%b ack%b want tx0 ack1", o_tx, o_rxack); end
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, $urandom(), 1'b1, 1'b0);
            checks++;
            if (o_tx !== 1'b1 || o_data !== 8'h00 || o_eop !== (j == 3)) begin
                failures++;
                $display("FAIL fl_newhdr[%0d]: got tx%b %h eop%b want tx1 00 eop%b", j, o_tx, o_data, o_eop, j == 3);
            end
        end
    endtask

    task automatic test_reset_midword();
        cyc(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, $urandom(), 1'b1, 1'b0);
        #1;
        checks++; if (eop_o !== 1'b1 || tx_o !== 1'b1) begin failures++; $display("FAIL rst_pre: got tx%b eop%b want tx1 eop1", tx_o, eop_o); end
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        checks++; if (tx_o !== 1'b0 || eop_o !== 1'b0) begin failures++; $display("FAIL rst_async: got tx%b eop%b want tx0 eop0", tx_o, eop_o); end
        @(negedge clk);
        rst_ni = 1'b1;
        cyc(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        checks++; if (o_rxack !== 1'b1) begin failures++; $display("FAIL rst_repop: got %b want 1", o_rxack); end
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, $urandom(), 1'b1, 1'b0);
            checks++;
            if (o_tx !== 1'b1 || o_data !== 8'h00 || o_eop !== (j == 3)) begin
                failures++;
                $display("FAIL rst_hdr[%0d]: got tx%b %h eop%b want tx1 00 eop%b", j, o_tx, o_data, o_eop, j == 3);
            end
        end
    endtask

    task automatic test_random(input int rx_pct, input int ack_pct);
        word_q_t w;
        flit_q_t ef;
        bit_q_t ee;
        bit_q_t none;
        int n;
        for (int p = 0; p < 6; p++) begin
            n = $urandom_range(3);
            w.push_back({16'($urandom()), 16'(n)});
            for (int k = 0; k < n; k++) w.push_back($urandom());
        end
        model(w, ef, ee);
        drive_stream(w, rx_pct, ack_pct, none, -1, 0, 3000);
        checks++; if (acc_data.size() != ef.size()) begin failures++; $display("FAIL rnd_count: got %0d want %0d", acc_data.size(), ef.size()); end
        for (int i = 0; i < ef.size() && i < acc_data.size(); i++) begin
            checks++;
            if (acc_data[i] !== ef[i] || acc_eop[i] !== ee[i]) begin
                failures++;
                $display("FAIL rnd_flit[%0d]: got %h/eop%b want %h/eop%b", i, acc_data[i], acc_eop[i], ef[i], ee[i]);
            end
        end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL rnd_stable: got %0d want 0", stall_viol); end
        checks++; if (ack_viol != 0) begin failures++; $display("FAIL rnd_rxack: got %0d want 0", ack_viol); end
        checks++; if (pops != w.size()) begin failures++; $display("FAIL rnd_pops: got %0d want %0d", pops, w.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_underflow();
        test_flush();
        test_reset_midword();
        test_random(70, 60);
        test_random(40, 90);
        test_random(95, 30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
